// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits answer one cycle after acceptance; misses evict a dirty victim (if any),
// refill the whole 16-word block, then answer from a dedicated response state.
module dcache_controller #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 16,
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_req_valid,
  output logic                            cpu_req_ready,
  input  logic                            cpu_req_we,
  input  logic [WORD_SIZE-1:0]            cpu_req_addr,
  input  logic [WORD_SIZE-1:0]            cpu_req_wdata,
  output logic                            cpu_resp_valid,
  output logic [WORD_SIZE-1:0]            cpu_resp_rdata,
  output logic [WORD_SIZE-1:0]            mem_ptr_out,
  input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_out_block,
  output logic [WORD_SIZE-1:0]            mem_ptr_in,
  output logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_in_block,
  output logic                            mem_write_enable,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
);

  localparam int IDX    = $clog2(NUM_LINES);
  localparam int OFF    = 4;
  localparam int TAG_W  = WORD_SIZE - OFF - IDX;
  localparam int LINE_W = BLOCK_SIZE * WORD_SIZE;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t state;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [LINE_W-1:0]    lines [NUM_LINES];

  logic [WORD_SIZE-1:0] lat_addr;
  logic                 lat_we;
  logic [WORD_SIZE-1:0] lat_wdata;
  logic [CNT_W-1:0]     wait_cnt;

  logic [OFF-1:0]   req_off;
  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF-1:0]   lat_off;
  logic [IDX-1:0]   lat_idx;
  logic [TAG_W-1:0] lat_tag;

  logic             accept;
  logic             hit;
  logic             store_hit;
  logic             fill_done;
  logic [LINE_W-1:0] fill_block;

  assign req_off = cpu_req_addr[OFF-1:0];
  assign req_idx = cpu_req_addr[OFF+IDX-1:OFF];
  assign req_tag = cpu_req_addr[WORD_SIZE-1:OFF+IDX];
  assign lat_off = lat_addr[OFF-1:0];
  assign lat_idx = lat_addr[OFF+IDX-1:OFF];
  assign lat_tag = lat_addr[WORD_SIZE-1:OFF+IDX];

  assign cpu_req_ready = (state == IDLE);
  assign accept        = cpu_req_valid && (state == IDLE);
  assign hit           = valid[req_idx] && (tags[req_idx] == req_tag);
  assign store_hit     = rst_n && accept && hit && cpu_req_we;
  assign fill_done     = rst_n && (state == FILL) && (wait_cnt == '0);

  // Word 0 of a block sits in the most significant bits
  function automatic logic [WORD_SIZE-1:0] get_word(input logic [LINE_W-1:0] blk,
                                                    input logic [OFF-1:0] off);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    for (int k = 0; k < BLOCK_SIZE; k++)
      if (off == OFF'(k)) w = blk[(BLOCK_SIZE-1-k)*WORD_SIZE +: WORD_SIZE];
    return w;
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] blk,
                                                 input logic [OFF-1:0] off,
                                                 input logic [WORD_SIZE-1:0] w);
    logic [LINE_W-1:0] b;
    b = blk;
    for (int k = 0; k < BLOCK_SIZE; k++)
      if (off == OFF'(k)) b[(BLOCK_SIZE-1-k)*WORD_SIZE +: WORD_SIZE] = w;
    return b;
  endfunction

  // Refill image: the memory block with the pending store word merged in
  always_comb begin
    fill_block = mem_out_block;
    if (lat_we) fill_block = put_word(mem_out_block, lat_off, lat_wdata);
  end

  // Tag and data arrays carry no reset state; only valid/dirty are cleared
  always_ff @(posedge clk) begin
    if (store_hit) lines[req_idx] <= put_word(lines[req_idx], req_off, cpu_req_wdata);
    if (fill_done) begin
      lines[lat_idx] <= fill_block;
      tags[lat_idx]  <= lat_tag;
    end
  end

  // Main controller: lookup, eviction, refill and response sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      valid            <= '0;
      dirty            <= '0;
      cpu_resp_valid   <= 1'b0;
      cpu_resp_rdata   <= '0;
      mem_write_enable <= 1'b0;
      mem_ptr_out      <= '0;
      mem_ptr_in       <= '0;
      mem_in_block     <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      wait_cnt         <= '0;
      lat_addr         <= '0;
      lat_we           <= 1'b0;
      lat_wdata        <= '0;
    end else begin
      cpu_resp_valid   <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              cpu_resp_valid <= 1'b1;
              if (cpu_req_we) dirty[req_idx] <= 1'b1;
              else            cpu_resp_rdata <= get_word(lines[req_idx], req_off);
              if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
              lat_addr  <= cpu_req_addr;
              lat_we    <= cpu_req_we;
              lat_wdata <= cpu_req_wdata;
              wait_cnt  <= CNT_LOAD;
              if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
              if (valid[req_idx] && dirty[req_idx]) begin
                state            <= WB;
                mem_ptr_in       <= {tags[req_idx], req_idx, 4'b0000};
                mem_in_block     <= lines[req_idx];
                mem_write_enable <= (MEM_LATENCY == 1);
              end else begin
                state       <= FILL;
                mem_ptr_out <= {req_tag, req_idx, 4'b0000};
              end
            end
          end
        end
        WB: begin
          if (wait_cnt == '0) begin
            state       <= FILL;
            wait_cnt    <= CNT_LOAD;
            mem_ptr_out <= {lat_tag, lat_idx, 4'b0000};
          end else begin
            wait_cnt         <= wait_cnt - CNT_ONE;
            mem_write_enable <= (wait_cnt == CNT_ONE);
          end
        end
        FILL: begin
          if (wait_cnt == '0) begin
            state          <= RESP;
            valid[lat_idx] <= 1'b1;
            dirty[lat_idx] <= lat_we;
            cpu_resp_valid <= 1'b1;
            if (!lat_we) cpu_resp_rdata <= get_word(mem_out_block, lat_off);
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
